lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit LFSR generator. Takes sampled LFSR words qualified by a strobe, since the generator runs on a divided clock.
- Synchronises to the sequence, then predicts each next word and flags mismatches.
- Keeps a saturating error count and drops lock after repeated misses.
- Used on the board to check a generator link or a shifted/captured LFSR stream.

Parameters:
- LOCK_CNT, 4: consecutive correct predictions in HUNT needed to declare lock (1..15).
- LOSS_CNT, 3: consecutive mispredictions in LOCKED that force return to HUNT (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk      input   1      system clock; all state on rising edge.
- rst      input   1      asynchronous, active-high reset.
- in_valid input   1      sample strobe; in_data is consumed only in cycles where in_valid=1.
- in_data  input   8      received LFSR word.
- err_clr  input   1      synchronous clear of err_cnt.
- locked   output  1      1 while in LOCKED.
- err      output  1      one-cycle pulse on a mispredicted sample while LOCKED.
- err_cnt  output  ERR_W  saturating count of mispredictions.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Next-state function, fixed and identical to the generator: nxt(v) = {v[4]^v[3]^v[2]^v[0], v[7:1]}.
- Internal registers:
  - state: HUNT or LOCKED.
  - exp[7:0]: expected next word.
  - seeded (1 bit).
  - run_cnt, miss_cnt: 4 bits each.
- Reset (async, any time, including mid-lock):
  - state=HUNT; exp, seeded, run_cnt, miss_cnt = 0.
  - Outputs: locked=0, err=0, err_cnt=0.
- All outputs are registered; every response appears the cycle after the sampled in_valid.
- Cycles with in_valid=0: no state change; err=0.
- HUNT, valid sample:
  - in_data==0x00 (illegal LFSR state): ignored entirely; seeded, run_cnt and exp are unchanged.
  - seeded=0: seeded<=1, exp<=nxt(in_data), run_cnt<=0.
  - seeded=1 and in_data==exp: run_cnt<=run_cnt+1, exp<=nxt(in_data). If run_cnt+1==LOCK_CNT then state<=LOCKED, miss_cnt<=0.
  - seeded=1 and in_data!=exp: reseed with exp<=nxt(in_data), run_cnt<=0.
  - err never pulses in HUNT; err_cnt is untouched.
- LOCKED, valid sample:
  - exp<=nxt(exp) on every sample (flywheel; no reseed on error).
  - Match: miss_cnt<=0.
  - Mismatch:
    - err<=1 for one cycle.
    - err_cnt<=err_cnt+1, saturating at all-ones.
    - miss_cnt<=miss_cnt+1.
    - If miss_cnt+1==LOSS_CNT: state<=HUNT, seeded<=0, run_cnt<=0.
- err_clr:
  - err_cnt<=0 next cycle.
  - If err_clr coincides with an error, clear wins (err_cnt=0), but err still pulses.
- Back-to-back valid samples every cycle are supported.

Optional Feature:
- Macro: LFSR_CHK_PERIOD_EN.
- With the macro defined:
  - Adds output period_ok (1 bit, reset 0).
  - An 8-bit counter counts valid samples while LOCKED, and the word latched at lock entry is held as a reference.
  - When exp returns to the reference: period_ok<=1 if the count equals 255, else period_ok<=0; the counter then restarts.
  - Leaving LOCKED clears period_ok and the counter.
- Without the macro: the port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Lock: reset, LOCK_CNT=4, feed valid 0x01,0x80,0x40,0x20,0x10 -> locked=1 the cycle after the 0x10 sample, err_cnt=0.
- Single error: locked after 0x10; feed 0xFF (expected 0x88) -> err pulses 1 cycle and err_cnt=1. Then feed 0xC4 -> no err, locked stays 1.
- Loss: locked, LOSS_CNT=3, feed three wrong words -> err pulses 3 times, err_cnt=3, locked=0 after the 3rd. Re-feeding a correct run of 5 words relocks.
- Zero/idle: in HUNT, feed 0x00 samples and gaps with in_valid=0 interleaved with 0x01,0x80,0x40,0x20,0x10 -> 0x00 ignored, lock still reached after 0x10.
- Saturation/clear: ERR_W=4, force 20 errors while relocking as needed -> err_cnt=15. err_clr together with an error -> err_cnt=0 and err=1.
- Async reset mid-lock: assert rst between clock edges while locked -> locked, err and err_cnt go to 0 immediately, and the checker restarts in HUNT.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR generator: hunts for lock, then flywheels and counts errors.
// Optional LFSR_CHK_PERIOD_EN adds a period_ok output confirming a full 255-sample sequence period.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef LFSR_CHK_PERIOD_EN
  ,
  output logic             period_ok
`endif
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic             seeded_q, seeded_d;
  logic [3:0]       run_cnt_q, run_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    seeded_d   = seeded_q;
    run_cnt_d  = run_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          // 0x00 is not a legal LFSR state, so it never seeds or breaks a run
          if (in_data != 8'h00) begin
            exp_d = nxt(in_data);
            if (seeded_q && (in_data == exp_q)) begin
              run_cnt_d = run_cnt_q + 4'd1;
              if (run_cnt_d == 4'(LOCK_CNT)) begin
                state_d    = StLocked;
                miss_cnt_d = 4'd0;
              end
            end else begin
              seeded_d  = 1'b1;
              run_cnt_d = 4'd0;
            end
          end
        end
        StLocked: begin
          // Flywheel: prediction advances regardless of what was received
          exp_d = nxt(exp_q);
          if (in_data == exp_q) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (miss_cnt_d == 4'(LOSS_CNT)) begin
              state_d   = StHunt;
              seeded_d  = 1'b0;
              run_cnt_d = 4'd0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (err_clr) err_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHunt;
      exp_q      <= 8'h00;
      seeded_q   <= 1'b0;
      run_cnt_q  <= 4'd0;
      miss_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      seeded_q   <= seeded_d;
      run_cnt_q  <= run_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked  = (state_q == StLocked);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

`ifdef LFSR_CHK_PERIOD_EN
  logic [7:0] per_cnt_q, per_cnt_d;
  logic [7:0] per_ref_q, per_ref_d;
  logic       period_ok_q, period_ok_d;
  logic [7:0] per_inc;

  always_comb begin
    per_cnt_d   = per_cnt_q;
    per_ref_d   = per_ref_q;
    period_ok_d = period_ok_q;
    per_inc     = per_cnt_q + 8'd1;
    if (in_valid) begin
      if ((state_q == StHunt) && (state_d == StLocked)) begin
        per_ref_d = exp_d;
        per_cnt_d = 8'd0;
      end else if ((state_q == StLocked) && (state_d == StHunt)) begin
        per_cnt_d   = 8'd0;
        period_ok_d = 1'b0;
      end else if (state_q == StLocked) begin
        // Prediction wrapped back to the lock-entry word: one full period elapsed
        if (exp_d == per_ref_q) begin
          period_ok_d = (per_inc == 8'd255);
          per_cnt_d   = 8'd0;
        end else begin
          per_cnt_d = per_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q   <= 8'd0;
      per_ref_q   <= 8'd0;
      period_ok_q <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      per_ref_q   <= per_ref_d;
      period_ok_q <= period_ok_d;
    end
  end

  assign period_ok = period_ok_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker against a sequence-level reference model.
module tb_lfsr_checker;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int EW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          err_clr = 1'b0;
  logic          locked;
  logic          err;
  logic [EW-1:0] err_cnt;
`ifdef LFSR_CHK_PERIOD_EN
  logic          period_ok;
`endif

  lfsr_checker #(
    .LOCK_CNT(LOCK),
    .LOSS_CNT(LOSS),
    .ERR_W   (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .err_clr  (err_clr),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
`ifdef LFSR_CHK_PERIOD_EN
    ,
    .period_ok(period_ok)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  // Reference model: lock is a chain of LOCK+1 successive nonzero words seen while hunting;
  // once locked, sample k must equal nxt applied k times to the word that completed the chain.
  bit         m_locked;
  bit         m_err;
  int         m_err_cnt;
  logic [7:0] hq[$];
  logic [7:0] lock_word;
  int         k;
  int         miss_run;

  function automatic int chain_len();
    int len;
    if (hq.size() == 0) return 0;
    len = 1;
    for (int i = hq.size() - 1; i > 0; i--) begin
      if (hq[i] == nxt(hq[i-1])) len++;
      else break;
    end
    return len;
  endfunction

  task automatic model_reset();
    m_locked  = 1'b0;
    m_err     = 1'b0;
    m_err_cnt = 0;
    hq.delete();
    k         = 0;
    miss_run  = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0] w;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (d != 8'h00) begin
          hq.push_back(d);
          if (chain_len() - 1 == LOCK) begin
            m_locked  = 1'b1;
            lock_word = d;
            k         = 0;
            miss_run  = 0;
            hq.delete();
          end
        end
      end else begin
        k++;
        w = lock_word;
        repeat (k) w = nxt(w);
        if (d == w) begin
          miss_run = 0;
        end else begin
          m_err = 1'b1;
          if (m_err_cnt < (1 << EW) - 1) m_err_cnt++;
          miss_run++;
          if (miss_run == LOSS) begin
            m_locked = 1'b0;
            hq.delete();
          end
        end
      end
    end
    if (c) m_err_cnt = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_step(in_valid, in_data, err_clr);
      #1;
      chk("cyc_locked", locked, m_locked);
      chk("cyc_err", err, m_err);
      chk("cyc_err_cnt", err_cnt, m_err_cnt);
    end
  end

  // Drives one cycle of input; returns 2 time units after the edge that consumed it
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    err_clr  = c;
    @(posedge clk);
    #2;
  endtask

  task automatic feed_lock();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h10, 1'b0);
  endtask

  int         nerr;
  int         r;
  logic [7:0] g;
  logic       c;

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Lock on a clean run
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    chk("lock_not_yet", locked, 0);
    step(1'b1, 8'h10, 1'b0);
    chk("lock_locked", locked, 1);
    chk("lock_model", m_locked, 1);
    chk("lock_err_cnt", err_cnt, 0);

    // Single error then recovery on the flywheel prediction
    step(1'b1, 8'hFF, 1'b0);
    chk("single_err", err, 1);
    chk("single_err_cnt", err_cnt, 1);
    step(1'b1, 8'hC4, 1'b0);
    chk("single_no_err", err, 0);
    chk("single_locked", locked, 1);
    step(1'b0, 8'hE2, 1'b1);
    chk("clr_err_cnt", err_cnt, 0);

    // Loss of lock after LOSS misses
    step(1'b1, 8'h55, 1'b0);
    chk("loss_err1", err, 1);
    step(1'b1, 8'h55, 1'b0);
    chk("loss_err2", err, 1);
    chk("loss_still_locked", locked, 1);
    step(1'b1, 8'h55, 1'b0);
    chk("loss_err3", err, 1);
    chk("loss_err_cnt", err_cnt, 3);
    chk("loss_unlocked", locked, 0);
    chk("loss_model", m_locked, 0);
    feed_lock();
    chk("relock", locked, 1);

    // Asynchronous reset between edges while locked
    step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_err_cnt", err_cnt, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err", err, 0);
    chk("arst_err_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Zeros and idle gaps interleaved with the lock run
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b0, 8'h33, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    chk("zero_not_yet", locked, 0);
    step(1'b1, 8'h10, 1'b0);
    chk("zero_locked", locked, 1);

    // Saturation of the error counter
    nerr = 0;
    while (nerr < 20) begin
      if (m_locked) begin
        step(1'b1, 8'h00, 1'b0);
        nerr++;
      end else begin
        feed_lock();
      end
    end
    chk("sat_err_cnt", err_cnt, 15);
    chk("sat_model", m_err_cnt, 15);
    if (!m_locked) feed_lock();
    step(1'b1, 8'h00, 1'b1);
    chk("clr_wins_err", err, 1);
    chk("clr_wins_cnt", err_cnt, 0);

    // Randomised stream: mostly correct successors with errors, zeros, gaps and clears
    g = 8'h5A;
    repeat (1500) begin
      r = $urandom_range(99);
      c = ($urandom_range(99) < 3);
      if (r < 15) begin
        step(1'b0, 8'($urandom), c);
      end else if (r < 20) begin
        step(1'b1, 8'h00, c);
      end else if (r < 26) begin
        step(1'b1, 8'($urandom), c);
      end else begin
        g = nxt(g);
        step(1'b1, g, c);
      end
    end

    step(1'b0, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
